// File: rtl/mux_rr_scheduler_pkg.sv
// Shared definitions for the mux round-robin scheduler: default sizing,
// FSM state codes and the one-hot helper.
package mux_sched_pkg;

  localparam int N_DEF        = 8;
  localparam int SEL_W_DEF    = 3;
  localparam int MAX_HOLD_DEF = 4;

  // FSM state codes
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  // One-hot vector with only bit idx set
  function automatic logic [N_DEF-1:0] onehot(input logic [SEL_W_DEF-1:0] idx);
    logic [N_DEF-1:0] v;
    v      = {N_DEF{1'b0}};
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/mux_rr_scheduler_if.sv
// Requester/mux side bundle of the scheduler: requests and data in,
// ownership, select and gated data bit out.
interface mux_rr_scheduler_if
  import mux_sched_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int SEL_W = SEL_W_DEF
);

  logic [N-1:0]     req;
  logic [N-1:0]     i;
  logic [N-1:0]     grant;
  logic [SEL_W-1:0] sel;
  logic             valid;
  logic             y;

  // requester side
  modport master (output req, output i, input grant, input sel, input valid, input y);
  // scheduler side
  modport slave  (input req, input i, output grant, output sel, output valid, output y);

endinterface

// File: rtl/mux_rr_scheduler_rr_pick.sv
// Combinational winner selection for the scheduler.
// Default: first set request scanning upward from ptr with wrap-around.
// With MUX_SCHED_FIXED_PRIO_EN defined: lowest-index set request wins.
module rr_pick
  import mux_sched_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int SEL_W = SEL_W_DEF
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] winner,
  output logic             any_req
);

  logic             found_s;
  logic [SEL_W-1:0] idx_s;

  // Visit every position once starting at ptr; keep the preferred hit
  always_comb begin
    winner  = {SEL_W{1'b0}};
    found_s = 1'b0;
    idx_s   = {SEL_W{1'b0}};
    for (int k = 0; k < N; k++) begin
      idx_s = ptr + SEL_W'(k);
`ifdef MUX_SCHED_FIXED_PRIO_EN
      // visit order is irrelevant here: smallest index always wins
      if (req[idx_s] && (!found_s || (idx_s < winner))) begin
        winner  = idx_s;
        found_s = 1'b1;
      end else begin
        found_s = found_s;
      end
`else
      // first hit in visit order wins
      if (req[idx_s] && !found_s) begin
        winner  = idx_s;
        found_s = 1'b1;
      end else begin
        found_s = found_s;
      end
`endif
    end
  end

  // Any pending request at all
  always_comb begin
    any_req = |req;
  end

endmodule

// File: rtl/mux_rr_scheduler.sv
// Round-robin owner arbitration for a shared N:1 bit-select mux.
// A grant lasts until the owner drops its request or MAX_HOLD cycles pass;
// one idle cycle always separates consecutive grants.
// Optional macro MUX_SCHED_FIXED_PRIO_EN switches arbitration (inside
// rr_pick) to fixed lowest-index priority; the pointer is still maintained.
module mux_rr_scheduler
  import mux_sched_pkg::*;
#(
  parameter int N        = N_DEF,
  parameter int SEL_W    = SEL_W_DEF,
  parameter int MAX_HOLD = MAX_HOLD_DEF
) (
  input  logic              clk,
  input  logic              rst,
  mux_rr_scheduler_if.slave bus
);

  localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

  logic [0:0]       state_r;
  logic [N-1:0]     grant_r;
  logic [SEL_W-1:0] sel_r;
  logic             valid_r;
  logic [SEL_W-1:0] ptr_r;
  logic [3:0]       hold_cnt_r;

  logic [SEL_W-1:0] winner_s;
  logic             any_req_s;
  logic [N_DEF-1:0] onehot_s;
  logic             y_s;

  rr_pick #(
    .N     (N),
    .SEL_W (SEL_W)
  ) u_pick (
    .req     (bus.req),
    .ptr     (ptr_r),
    .winner  (winner_s),
    .any_req (any_req_s)
  );

  // One-hot form of the current winner
  always_comb begin
    onehot_s = onehot(SEL_W_DEF'(winner_s));
  end

  // Ownership FSM: grant from IDLE, hold or release in GRANT
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      grant_r    <= {N{1'b0}};
      sel_r      <= {SEL_W{1'b0}};
      valid_r    <= 1'b0;
      ptr_r      <= {SEL_W{1'b0}};
      hold_cnt_r <= 4'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (any_req_s) begin
            grant_r    <= onehot_s[N-1:0];
            sel_r      <= winner_s;
            valid_r    <= 1'b1;
            hold_cnt_r <= 4'd0;
            state_r    <= GRANT;
          end else begin
            state_r    <= IDLE;
          end
        end
        GRANT: begin
          if (bus.req[sel_r] && (hold_cnt_r < HOLD_LAST)) begin
            hold_cnt_r <= hold_cnt_r + 4'd1;
          end else begin
            // sel keeps its value; the pointer moves past the old owner
            grant_r <= {N{1'b0}};
            valid_r <= 1'b0;
            ptr_r   <= sel_r + SEL_W'(1);
            state_r <= IDLE;
          end
        end
        default: begin
          grant_r    <= {N{1'b0}};
          valid_r    <= 1'b0;
          hold_cnt_r <= 4'd0;
          state_r    <= IDLE;
        end
      endcase
    end
  end

  // Gate the selected data bit with ownership
  always_comb begin
    if (valid_r) begin
      y_s = bus.i[sel_r];
    end else begin
      y_s = 1'b0;
    end
  end

  assign bus.grant = grant_r;
  assign bus.sel   = sel_r;
  assign bus.valid = valid_r;
  assign bus.y     = y_s;

endmodule

// File: doc/mux_rr_scheduler.md
Name: mux_rr_scheduler

Overview:
- Round-robin scheduler that shares one 8:1 bit-select datapath among N requesters.
- Each cycle it decides which requester owns the mux and drives the 3-bit select.
- It gates the selected data bit onto y.
- It sits in front of the 8:1 mux and replaces the free-running select with arbitrated, time-bounded ownership.

Parameters:
- N, 8, number of requesters and mux inputs (power of two, 2..8).
- SEL_W, 3, select width, equal to log2(N).
- MAX_HOLD, 4, maximum consecutive cycles one owner may keep the grant (1..15).

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- req  input  N  request per requester; held high while ownership is wanted.
- i  input  N  data bits, one per requester.
- grant  output  N  one-hot owner, registered; all zeros when idle.
- sel  output  SEL_W  registered select for the mux; equals the index of the grant bit.
- valid  output  1  high while an owner holds the mux.
- y  output  1  equals i[sel] when valid=1, else 0; combinational from registered sel/valid.

Behaviour:
- Interface: one clock; reset is synchronous and active-high. Ports are clk and rst.
- Reset (rst=1 at a clock edge):
  - state=IDLE; grant=0, sel=0, valid=0; ptr=0, hold_cnt=0. y therefore reads 0.
  - Reset wins over every other event, including mid-grant; ownership is dropped without a release cycle.
- State IDLE:
  - If req==0, remain in IDLE.
  - Otherwise the winner is the first set req bit scanning upward from ptr, wrapping N-1 to 0.
  - At the next edge: grant=onehot(winner), sel=winner, valid=1, hold_cnt=0, state=GRANT.
  - Latency from req rise to grant is 1 cycle.
- State GRANT:
  - Each edge where req[sel]=1 and hold_cnt<MAX_HOLD-1: stay, hold_cnt+=1.
  - Release when req[sel]=0 OR hold_cnt==MAX_HOLD-1.
  - On release: grant=0, valid=0, ptr=(sel+1) mod N, state=IDLE. sel retains its value.
- Bubble rule: exactly one IDLE cycle always separates two grants, even when other requests are pending.
- Owner re-request: a requester whose hold expired may win again only after every other active requester, by pointer order.
- Requests from non-owners during GRANT are ignored; no state change.
- ptr updates only on release; it is never changed by arbitration in IDLE.
- Arithmetic:
  - ptr and scan indices are mod N.
  - hold_cnt is 4 bits, unsigned, and never exceeds MAX_HOLD-1.
- Invariants:
  - grant is one-hot or zero.
  - valid == |grant.
  - When valid=1, grant[sel]=1.

Optional Feature:
- Macro: MUX_SCHED_FIXED_PRIO_EN.
- Defined: arbitration in IDLE ignores ptr; the lowest-index set req bit wins. ptr is still maintained, so debug readback is unchanged. The MAX_HOLD limit still applies.
- Undefined: round-robin from ptr, as above.

Decomposition:
- Shared package mux_sched_pkg:
  - state enum {IDLE, GRANT}.
  - Default constants N=8, SEL_W=3, MAX_HOLD=4.
  - Function onehot(idx).
- One natural sub-module, rr_pick: purely combinational. Inputs req and ptr; outputs winner index and any_req; the fixed-priority macro branch lives inside it.
- The y gating stays in the top, since it is a single indexed select.

Test Plan:
- Reset, then req=8'h00 for 5 cycles -> valid=0, grant=0, sel=0, y=0 throughout.
- req=8'h10 held, i=8'h10 -> valid rises 1 cycle later with sel=4, y=1. Owner is released after 4 grant cycles, followed by 1 IDLE cycle, then regranted to 4.
- req=8'h81 held from reset (ptr=0) -> grant sequence 0,7,0,7, each 4 cycles long, separated by 1 idle cycle. With MUX_SCHED_FIXED_PRIO_EN defined: 0,0,0,...
- Owner 2 drops req after 2 grant cycles while req[5]=1 -> release, one idle cycle, then sel=5; ptr was 3 at the decision.
- Assert rst during the 2nd grant cycle of owner 6 -> next edge: grant=0, valid=0, sel=0. The first grant after reset follows ptr=0.
- Random req/i for 10k cycles -> invariants hold every cycle: one-hot grant, valid==|grant, y==(valid ? i[sel] : 0), hold length ≤ MAX_HOLD.
